// File: rtl/snake_move_if.sv
// rtl/snake_move_if.sv - key, growth, query and status signals of the snake controller
interface snake_move_if;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       key_start;
  logic       add_cube;
  logic [5:0] query_x;
  logic [4:0] query_y;
  logic [5:0] head_x;
  logic [5:0] head_y;
  logic [1:0] status;
  logic [4:0] length;
  logic       step;
  logic       query_hit;

  modport master (
    output key_up, key_down, key_left, key_right, key_start, add_cube, query_x, query_y,
    input  head_x, head_y, status, length, step, query_hit
  );

  modport slave (
    input  key_up, key_down, key_left, key_right, key_start, add_cube, query_x, query_y,
    output head_x, head_y, status, length, step, query_hit
  );
endinterface

// File: rtl/snake_move.sv
// rtl/snake_move.sv - snake movement, body shift register, growth and collision detection
module snake_move #(
  parameter int MAX_LEN     = 16,
  parameter int STEP_CYCLES = 12_500_000,
  parameter int INIT_LEN    = 3
) (
  input logic         clk,
  input logic         rst,
  snake_move_if.slave bus
);
  localparam int CNT_W = $clog2(STEP_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_DIE = 2'd2} state_t;
  // Opposite directions share bit 1 and differ in bit 0.
  typedef enum logic [1:0] {D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3} dir_t;

  state_t           state_q, state_d;
  dir_t             dir_q, dir_next_q, key_dir;
  logic             key_any, key_accept;
  logic [CNT_W-1:0] tick_q;
  logic             grow_pending_q;
  logic [5:0]       seg_x [MAX_LEN];
  logic [4:0]       seg_y [MAX_LEN];
  logic [4:0]       len_q;
  logic             step_q, query_hit_q;

  logic             terminal, grow, wall_hit, self_hit, hit, query_match;
  logic [5:0]       nx;
  logic [4:0]       ny;
  logic [4:0]       chk_len;

  assign terminal = (state_q == S_PLAY) && (tick_q == CNT_W'(STEP_CYCLES - 1));
  assign grow     = grow_pending_q | bus.add_cube;

  always_comb begin
    key_any = 1'b1;
    key_dir = D_RIGHT;
    if (bus.key_up)         key_dir = D_UP;
    else if (bus.key_down)  key_dir = D_DOWN;
    else if (bus.key_left)  key_dir = D_LEFT;
    else if (bus.key_right) key_dir = D_RIGHT;
    else                    key_any = 1'b0;
    key_accept = key_any && !((key_dir[1] == dir_q[1]) && (key_dir[0] != dir_q[0]));
  end

  always_comb begin
    nx = seg_x[0];
    ny = seg_y[0];
    case (dir_next_q)
      D_UP:    ny = seg_y[0] - 5'd1;
      D_DOWN:  ny = seg_y[0] + 5'd1;
      D_LEFT:  nx = seg_x[0] - 6'd1;
      default: nx = seg_x[0] + 6'd1;
    endcase
    wall_hit = (nx == 6'd0) || (nx == 6'd39) || (ny == 5'd0) || (ny == 5'd29);
    // The tail cube is free to enter only when it vacates, i.e. when not growing.
    chk_len  = grow ? len_q : len_q - 5'd1;
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < chk_len) && (seg_x[i] == nx) && (seg_y[i] == ny)) self_hit = 1'b1;
    end
    hit = wall_hit | self_hit;
  end

  always_comb begin
    query_match = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < len_q) && (seg_x[i] == bus.query_x) && (seg_y[i] == bus.query_y))
        query_match = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.key_start) state_d = S_PLAY;
      S_PLAY:  if (terminal && hit) state_d = S_DIE;
      S_DIE:   if (bus.key_start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || ((state_q == S_DIE) && bus.key_start)) begin
      tick_q         <= '0;
      grow_pending_q <= 1'b0;
      dir_q          <= D_RIGHT;
      dir_next_q     <= D_RIGHT;
      len_q          <= 5'(INIT_LEN);
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= 6'(20 - i);
        seg_y[i] <= 5'd15;
      end
    end else if (state_q == S_IDLE) begin
      tick_q <= '0;
    end else if (state_q == S_PLAY) begin
      if (key_accept) dir_next_q <= key_dir;
      if (terminal) begin
        tick_q <= '0;
        if (!hit) begin
          dir_q <= dir_next_q;
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nx;
          seg_y[0] <= ny;
          if (grow && (len_q < 5'(MAX_LEN))) len_q <= len_q + 5'd1;
          grow_pending_q <= 1'b0;
        end
      end else begin
        tick_q <= tick_q + 1'b1;
        if (bus.add_cube) grow_pending_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q      <= 1'b0;
      query_hit_q <= 1'b0;
    end else begin
      step_q      <= terminal && !hit;
      query_hit_q <= query_match;
    end
  end

  assign bus.head_x    = seg_x[0];
  assign bus.head_y    = {1'b0, seg_y[0]};
  assign bus.status    = state_q;
  assign bus.length    = len_q;
  assign bus.step      = step_q;
  assign bus.query_hit = query_hit_q;
endmodule

// File: tb/tb_snake_move.sv
// tb/tb_snake_move.sv - directed self-checking bench for snake_move
module tb_snake_move;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snake_move_if bus ();

  snake_move #(.MAX_LEN(16), .STEP_CYCLES(4), .INIT_LEN(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [5:0] P_START = 6'b100000;
  localparam logic [5:0] P_ADD   = 6'b010000;
  localparam logic [5:0] P_UP    = 6'b001000;
  localparam logic [5:0] P_DOWN  = 6'b000100;
  localparam logic [5:0] P_LEFT  = 6'b000010;
  localparam logic [5:0] P_RIGHT = 6'b000001;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [5:0] v);
    {bus.key_start, bus.add_cube, bus.key_up, bus.key_down, bus.key_left, bus.key_right} = v;
    @(negedge clk);
    {bus.key_start, bus.add_cube, bus.key_up, bus.key_down, bus.key_left, bus.key_right} = '0;
  endtask

  task automatic wait_step(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.step && n < 8);
    check({tag, " step"}, 32'(bus.step), 32'd1);
  endtask

  task automatic wait_die(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen |= bus.step;
    end
    check({tag, " status"}, 32'(bus.status), 32'd2);
    check({tag, " no step"}, 32'(seen), 32'd0);
  endtask

  task automatic check_head(input string tag, input int x, input int y);
    check({tag, " head_x"}, 32'(bus.head_x), 32'(x));
    check({tag, " head_y"}, 32'(bus.head_y), 32'(y));
  endtask

  initial begin
    rst = 1'b1;
    {bus.key_start, bus.add_cube, bus.key_up, bus.key_down, bus.key_left, bus.key_right} = '0;
    bus.query_x = 6'd0;
    bus.query_y = 5'd0;
    repeat (2) @(negedge clk);
    check("rst status", 32'(bus.status), 32'd0);
    check_head("rst", 20, 15);
    check("rst length", 32'(bus.length), 32'd3);
    check("rst step", 32'(bus.step), 32'd0);
    check("rst query_hit", 32'(bus.query_hit), 32'd0);
    rst = 1'b0;

    // Start: first step lands exactly STEP_CYCLES cycles after key_start.
    pulse(P_START);
    check("start status", 32'(bus.status), 32'd1);
    repeat (3) @(negedge clk);
    check("pre-step step", 32'(bus.step), 32'd0);
    check_head("pre-step", 20, 15);
    @(negedge clk);
    check("first step", 32'(bus.step), 32'd1);
    check_head("first", 21, 15);

    pulse(P_LEFT);
    wait_step("reverse");
    check_head("reverse", 22, 15);
    pulse(P_UP | P_DOWN);
    wait_step("updown");
    check_head("updown", 22, 14);

    // Single growth, then body query at the kept tail and one past it.
    pulse(P_ADD);
    wait_step("grow1");
    check_head("grow1", 22, 13);
    check("grow1 length", 32'(bus.length), 32'd4);
    bus.query_x = 6'd21;
    bus.query_y = 5'd15;
    @(negedge clk);
    check("tail hit", 32'(bus.query_hit), 32'd1);
    bus.query_x = 6'd20;
    pulse(P_ADD);
    check("past tail", 32'(bus.query_hit), 32'd0);
    pulse(P_ADD);
    wait_step("grow2");
    check("merged growth length", 32'(bus.length), 32'd5);
    check_head("grow2", 22, 12);
    wait_step("plain");
    check("no leftover growth", 32'(bus.length), 32'd5);
    check_head("plain", 22, 11);

    // Self collision: LEFT, DOWN, RIGHT folds the head onto segment 3.
    pulse(P_LEFT);
    wait_step("turn left");
    check_head("turn left", 21, 11);
    pulse(P_DOWN);
    wait_step("turn down");
    check_head("turn down", 21, 12);
    pulse(P_RIGHT);
    wait_die("self");
    check_head("self frozen", 21, 12);
    pulse(P_ADD);
    repeat (5) @(negedge clk);
    check("die length", 32'(bus.length), 32'd5);
    check("die status held", 32'(bus.status), 32'd2);

    // Restart and run into the right wall.
    pulse(P_START);
    check("restart status", 32'(bus.status), 32'd0);
    check_head("restart", 20, 15);
    check("restart length", 32'(bus.length), 32'd3);
    pulse(P_START);
    wait_step("wall 1");
    pulse(P_START);
    check("start in play", 32'(bus.status), 32'd1);
    for (int s = 2; s <= 18; s++) wait_step("wall run");
    check_head("wall edge", 38, 15);
    wait_die("wall");
    check_head("wall frozen", 38, 15);

    // Reset in the middle of play.
    pulse(P_START);
    pulse(P_START);
    wait_step("pre-rst");
    check_head("pre-rst", 21, 15);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst status", 32'(bus.status), 32'd0);
    check_head("mid rst", 20, 15);
    check("mid rst length", 32'(bus.length), 32'd3);
    bus.query_x = 6'd18;
    bus.query_y = 5'd15;
    @(negedge clk);
    check("rst tail hit", 32'(bus.query_hit), 32'd1);
    bus.query_x = 6'd17;
    @(negedge clk);
    check("rst invalid seg", 32'(bus.query_hit), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
